// File: rtl/ram_arbiter.sv
// Two-port front end for a single registered-read RAM: zero-fills after reset, then
// grants at most one fetch/data operation per cycle with round-robin on ties.
module ram_arbiter #(
  parameter int DataWidth    = 16,
  parameter int NumRegs      = 8,
  parameter int IndexWidth   = $clog2(NumRegs),
  parameter bit ClearOnReset = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [IndexWidth-1:0] addr0,
  input  logic [IndexWidth-1:0] addr1,
  input  logic [DataWidth-1:0]  wdata0,
  input  logic [DataWidth-1:0]  wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DataWidth-1:0]  rdata,
  output logic                  busy,
  output logic                  ramWriteEnable,
  output logic [IndexWidth-1:0] ramWriteAddr,
  output logic [DataWidth-1:0]  ramWriteData,
  output logic [IndexWidth-1:0] ramReadAddr,
  input  logic [DataWidth-1:0]  ramReadData,
  output logic [0:0]            dbg_state
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;
  localparam logic [IndexWidth:0]   NUM_REGS_W = (IndexWidth+1)'(NumRegs);
  localparam logic [IndexWidth-1:0] LAST_IDX   = IndexWidth'(NumRegs - 1);

  logic [0:0]            state;
  logic [IndexWidth-1:0] clear_idx;
  logic                  last_gnt;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic                  rd_oob_q;
  logic                  busy_q;
  logic                  in_range0;
  logic                  in_range1;

  assign in_range0 = {1'b0, addr0} < NUM_REGS_W;
  assign in_range1 = {1'b0, addr1} < NUM_REGS_W;

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gntI high;
  // the operation is consumed at the rising edge that ends that cycle.
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    ramWriteEnable = 1'b0;
    ramWriteAddr   = '0;
    ramWriteData   = '0;
    ramReadAddr    = '0;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        ramWriteEnable = 1'b1;
        ramWriteAddr   = clear_idx;
      end else begin
        gnt0 = req0 & (~req1 | last_gnt);
        gnt1 = req1 & (~req0 | ~last_gnt);
        if (gnt0) begin
          if (we0) begin
            ramWriteEnable = in_range0;
            ramWriteAddr   = addr0;
            ramWriteData   = wdata0;
          end else begin
            ramReadAddr = addr0;
          end
        end else if (gnt1) begin
          if (we1) begin
            ramWriteEnable = in_range1;
            ramWriteAddr   = addr1;
            ramWriteData   = wdata1;
          end else begin
            ramReadAddr = addr1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ClearOnReset ? ST_CLEAR : ST_SERVE;
      clear_idx <= '0;
      last_gnt  <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd_oob_q  <= 1'b0;
      busy_q    <= ClearOnReset;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      rd_oob_q  <= gnt0 ? ~in_range0 : ~in_range1;
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
      if (state == ST_CLEAR) begin
        clear_idx <= clear_idx + 1'b1;
        if (clear_idx == LAST_IDX) begin
          state  <= ST_SERVE;
          busy_q <= 1'b0;
        end
      end
    end
  end

  // A read in flight when reset arrives never reaches its requester.
  assign rvalid0   = rvalid0_q & ~rst;
  assign rvalid1   = rvalid1_q & ~rst;
  assign rdata     = ((rvalid0_q | rvalid1_q) & ~rd_oob_q) ? ramReadData : '0;
  assign busy      = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: an 8-deep clearing instance checked every cycle against a
// behavioural model, plus a 6-deep non-clearing instance for out-of-range access.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [15:0] rdata;
  logic        ram_we;
  logic [2:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [0:0]  dbg_state;

  logic        b_req0, b_req1, b_we0, b_we1;
  logic [2:0]  b_addr0, b_addr1;
  logic [15:0] b_wdata0, b_wdata1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy;
  logic [15:0] b_rdata;
  logic        b_ram_we;
  logic [2:0]  b_ram_waddr, b_ram_raddr;
  logic [15:0] b_ram_wdata, b_ram_rdata;
  logic [0:0]  b_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  ram_arbiter #(.DataWidth(16), .NumRegs(8), .ClearOnReset(1'b1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ramWriteEnable(ram_we), .ramWriteAddr(ram_waddr),
    .ramWriteData(ram_wdata), .ramReadAddr(ram_raddr), .ramReadData(ram_rdata),
    .dbg_state(dbg_state)
  );

  ram_arbiter #(.DataWidth(16), .NumRegs(6), .ClearOnReset(1'b0)) dut6 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .busy(b_busy), .ramWriteEnable(b_ram_we), .ramWriteAddr(b_ram_waddr),
    .ramWriteData(b_ram_wdata), .ramReadAddr(b_ram_raddr), .ramReadData(b_ram_rdata),
    .dbg_state(b_dbg_state)
  );

  // Registered-read RAMs preloaded with a non-zero pattern so the zero-fill is observable.
  logic [15:0] ram8 [8] = '{default: 16'hDEAD};
  logic [15:0] ram6 [8] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    if (ram_we) ram8[ram_waddr] <= ram_wdata;
    ram_rdata <= ram8[ram_raddr];
    if (b_ram_we) ram6[b_ram_waddr] <= b_ram_wdata;
    b_ram_rdata <= ram6[b_ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the 8-deep instance: remaining clear cycles, last winner,
  // expected RAM contents and the read response owed next cycle.
  logic [15:0] m_mem [8];
  int          m_clear = 0;
  int          m_last  = 1;
  bit          m_live  = 1'b0;
  bit          m_pv0   = 1'b0;
  bit          m_pv1   = 1'b0;
  logic [15:0] m_pd    = '0;

  task automatic model_step();
    int          g;
    logic        op_we;
    logic [2:0]  a;
    logic [15:0] wd;
    if (rst) begin
      if (m_live) begin
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_wen", ram_we, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
      end
      m_live  = 1'b1;
      m_clear = 8;
      m_last  = 1;
      m_pv0   = 1'b0;
      m_pv1   = 1'b0;
    end else if (m_live) begin
      check("m_busy", busy, m_clear > 0);
      check("m_rvalid0", rvalid0, m_pv0);
      check("m_rvalid1", rvalid1, m_pv1);
      if (m_pv0 || m_pv1) check("m_rdata", rdata, m_pd);
      m_pv0 = 1'b0;
      m_pv1 = 1'b0;
      if (m_clear > 0) begin
        check("m_clr_wen", ram_we, 1);
        check("m_clr_waddr", ram_waddr, 8 - m_clear);
        check("m_clr_wdata", ram_wdata, 0);
        check("m_clr_gnt", {gnt1, gnt0}, 0);
        m_mem[8 - m_clear] = '0;
        m_clear--;
      end else begin
        if (req0 && req1) g = (m_last == 0) ? 1 : 0;
        else if (req0)    g = 0;
        else if (req1)    g = 1;
        else              g = -1;
        check("m_gnt0", gnt0, g == 0);
        check("m_gnt1", gnt1, g == 1);
        if (g < 0) begin
          check("m_idle_wen", ram_we, 0);
          check("m_idle_raddr", ram_raddr, 0);
          check("m_idle_waddr", ram_waddr, 0);
          check("m_idle_wdata", ram_wdata, 0);
        end else begin
          op_we = (g == 0) ? we0 : we1;
          a     = (g == 0) ? addr0 : addr1;
          wd    = (g == 0) ? wdata0 : wdata1;
          if (op_we) begin
            check("m_wen", ram_we, 1);
            check("m_waddr", ram_waddr, a);
            check("m_wdata", ram_wdata, wd);
            m_mem[a] = wd;
          end else begin
            check("m_rd_wen", ram_we, 0);
            check("m_raddr", ram_raddr, a);
            if (g == 0) m_pv0 = 1'b1; else m_pv1 = 1'b1;
            m_pd = m_mem[a];
          end
          m_last = g;
        end
      end
    end
  endtask

  // Driver: model runs at the falling edge, inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] pat [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  bit g0, g1;

  initial begin
    rst = 1'b1;
    {req0, req1, we0, we1, addr0, addr1, wdata0, wdata1} = '0;
    {b_req0, b_req1, b_we0, b_we1, b_addr0, b_addr1, b_wdata0, b_wdata1} = '0;
    req0 = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Zero-fill with req0 waiting: 8 clear cycles, grant in cycle 9
    for (int c = 1; c <= 9; c++) begin
      #2;
      if (c <= 8) begin
        check("t1_gnt0_wait", gnt0, 0);
        check("t1_busy", busy, 1);
        check("t1_clr_addr", ram_waddr, c - 1);
      end else begin
        check("t1_gnt0_cycle9", gnt0, 1);
        check("t1_busy_low", busy, 0);
      end
      tick();
    end
    req0 = 1'b0;
    #2;
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata", rdata, 16'h0000);

    // Read addr 3 after clear
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3;
    #2 check("t2_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    #2;
    check("t2_rvalid0", rvalid0, 1);
    check("t2_rdata", rdata, 16'h0000);

    // Write then read-back of 0xBEEF at addr 5
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd5; wdata1 = 16'hBEEF;
    #2;
    check("t3_gnt1", gnt1, 1);
    check("t3_wen", ram_we, 1);
    check("t3_wdata", ram_wdata, 16'hBEEF);
    tick();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5;
    #2 check("t3_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    #2;
    check("t3_rvalid0", rvalid0, 1);
    check("t3_rvalid1", rvalid1, 0);
    check("t3_rdata", rdata, 16'hBEEF);

    // Both requesters from the first SERVE cycle: 0,1,0,1
    tick();
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h0A0A;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      #2;
      check("t4_gnt_pattern", {gnt1, gnt0}, pat[k]);
      if (k == 1) check("t4_rvalid0_k1", rvalid0, 1);
      if (k == 2) check("t4_rvalid_k2", {rvalid1, rvalid0}, 0);
      if (k == 3) begin
        check("t4_rvalid0_k3", rvalid0, 1);
        check("t4_rdata_k3", rdata, 16'h0A0A);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset right after a read grant drops the response and restarts the fill
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    #2 check("t5_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0; rst = 1'b1;
    #2 check("t5_rvalid0_dropped", rvalid0, 0);
    tick();
    rst = 1'b0;
    #2;
    check("t5_busy", busy, 1);
    check("t5_clr_addr0", ram_waddr, 0);
    check("t5_clr_wen", ram_we, 1);

    // Randomised traffic with hold-until-granted requesters
    g0 = 1'b0; g1 = 1'b0;
    tick();
    for (int n = 0; n < 80; n++) begin
      if (!req0 || g0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = 3'($urandom_range(0, 7)); wdata0 = 16'($urandom_range(0, 65535));
      end
      if (!req1 || g1) begin
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = 3'($urandom_range(0, 7)); wdata1 = 16'($urandom_range(0, 65535));
      end
      #2;
      g0 = gnt0; g1 = gnt1;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // 6-deep instance: addr 7 is out of range
    #2 check("t6_busy", b_busy, 0);
    tick();
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 3'd7; b_wdata0 = 16'h1234;
    #2;
    check("t6_gnt0_wr", b_gnt0, 1);
    check("t6_wen_oob", b_ram_we, 0);
    tick();
    b_we0 = 1'b0;
    #2;
    check("t6_gnt0_rd", b_gnt0, 1);
    check("t6_raddr", b_ram_raddr, 7);
    tick();
    b_req0 = 1'b0;
    #2;
    check("t6_rvalid0", b_rvalid0, 1);
    check("t6_rdata_oob", b_rdata, 16'h0000);
    tick();
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 3'd5; b_wdata1 = 16'h5555;
    #2 check("t6_wen_in_range", b_ram_we, 1);
    tick();
    b_we1 = 1'b0;
    #2 check("t6_gnt1_rd", b_gnt1, 1);
    tick();
    b_req1 = 1'b0;
    #2;
    check("t6_rvalid1", b_rvalid1, 1);
    check("t6_rdata5", b_rdata, 16'h5555);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
